// File: rtl/ppu_spr_shift.sv
// Sprite output stage: eight slot shifters, priority mux
// and the sticky sprite-0 hit flag.
module ppu_spr_shift (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x_idx,
  input  logic [9:0] scanline,
  input  logic       ld_en,
  input  logic [2:0] ld_slot,
  input  logic [7:0] ld_pt_lo,
  input  logic [7:0] ld_pt_hi,
  input  logic [7:0] ld_attr,
  input  logic [7:0] ld_x,
  input  logic       ld_spr0,
  input  logic [3:0] bg_pixel,
  input  logic       show_spr,
  input  logic       show_spr_left,
  input  logic       show_bg_left,
  output logic [3:0] pixel,
  output logic       spr_behind,
  output logic       spr0_hit
);

  logic [7:0] pt_lo [8];
  logic [7:0] pt_hi [8];
  logic [7:0] xcnt  [8];
  logic [1:0] pal   [8];
  logic [7:0] prio;
  logic [7:0] is0;

  logic       vis_line;
  logic       shift_en;
  logic       ld_win;
  logic       left;
  logic       mask;
  logic       hit_ok;
  logic [1:0] cand [8];
  logic [7:0] opq;
  logic       win;
  logic [3:0] win_pix;
  logic       win_prio;

  logic unused_ok;
  assign unused_ok = &{1'b0, ld_attr[7],
                       ld_attr[4:2], bg_pixel[3:2]};

  function automatic logic [7:0] rev8(
    input logic [7:0] v
  );
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  assign vis_line = scanline >= 10'd1 &&
                    scanline <= 10'd240;
  assign shift_en = vis_line && x_idx >= 10'd1 &&
                    x_idx <= 10'd256;
  assign ld_win   = x_idx >= 10'd257 &&
                    x_idx <= 10'd320;
  assign left     = x_idx <= 10'd8;
  assign mask     = !show_spr ||
                    (!show_spr_left && left);

  // Lowest slot wins: scan high to low, last hit sticks.
  always_comb begin
    win      = 1'b0;
    win_pix  = 4'd0;
    win_prio = 1'b0;
    opq      = 8'd0;
    for (int i = 0; i < 8; i++) begin
      cand[i] = {pt_hi[i][7], pt_lo[i][7]};
      opq[i]  = xcnt[i] == 8'd0 && cand[i] != 2'd0;
    end
    for (int i = 7; i >= 0; i--) begin
      if (opq[i]) begin
        win      = 1'b1;
        win_pix  = {pal[i], cand[i]};
        win_prio = prio[i];
      end
    end
  end

  assign hit_ok = shift_en && |(opq & is0) &&
                  bg_pixel[1:0] != 2'd0 && show_spr &&
                  x_idx != 10'd256 &&
                  !(left && (!show_spr_left ||
                             !show_bg_left));

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel      <= 4'd0;
      spr_behind <= 1'b0;
      spr0_hit   <= 1'b0;
      prio       <= 8'd0;
      is0        <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        pt_lo[i] <= 8'd0;
        pt_hi[i] <= 8'd0;
        xcnt[i]  <= 8'd0;
        pal[i]   <= 2'd0;
      end
    end else begin
      if (shift_en && win && !mask) begin
        pixel      <= win_pix;
        spr_behind <= win_prio;
      end else begin
        pixel      <= 4'd0;
        spr_behind <= 1'b0;
      end
      if (scanline == 10'd0 && x_idx == 10'd1)
        spr0_hit <= 1'b0;
      else if (hit_ok)
        spr0_hit <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (shift_en) begin
          if (xcnt[i] != 8'd0) begin
            xcnt[i] <= xcnt[i] - 8'd1;
          end else begin
            pt_lo[i] <= {pt_lo[i][6:0], 1'b0};
            pt_hi[i] <= {pt_hi[i][6:0], 1'b0};
          end
        end
        if (x_idx == 10'd257) begin
          pt_lo[i] <= 8'd0;
          pt_hi[i] <= 8'd0;
          is0[i]   <= 1'b0;
        end
        if (ld_win && ld_en && ld_slot == 3'(i)) begin
          pt_lo[i] <= ld_attr[6] ? rev8(ld_pt_lo)
                                 : ld_pt_lo;
          pt_hi[i] <= ld_attr[6] ? rev8(ld_pt_hi)
                                 : ld_pt_hi;
          pal[i]   <= ld_attr[1:0];
          prio[i]  <= ld_attr[5];
          is0[i]   <= ld_spr0;
          xcnt[i]  <= ld_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppu_spr_shift.sv
// Randomised scoreboard bench for ppu_spr_shift against
// a sprite-list reference model.
module tb_ppu_spr_shift;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x_idx = '0;
  logic [9:0] scanline = '0;
  logic       ld_en = 1'b0;
  logic [2:0] ld_slot = '0;
  logic [7:0] ld_pt_lo = '0;
  logic [7:0] ld_pt_hi = '0;
  logic [7:0] ld_attr = '0;
  logic [7:0] ld_x = '0;
  logic       ld_spr0 = 1'b0;
  logic [3:0] bg_pixel = '0;
  logic       show_spr = 1'b1;
  logic       show_spr_left = 1'b1;
  logic       show_bg_left = 1'b1;
  logic [3:0] pixel;
  logic       spr_behind;
  logic       spr0_hit;

  ppu_spr_shift dut (
    .clk(clk), .reset(reset), .x_idx(x_idx),
    .scanline(scanline), .ld_en(ld_en),
    .ld_slot(ld_slot), .ld_pt_lo(ld_pt_lo),
    .ld_pt_hi(ld_pt_hi), .ld_attr(ld_attr),
    .ld_x(ld_x), .ld_spr0(ld_spr0),
    .bg_pixel(bg_pixel), .show_spr(show_spr),
    .show_spr_left(show_spr_left),
    .show_bg_left(show_bg_left), .pixel(pixel),
    .spr_behind(spr_behind), .spr0_hit(spr0_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [7:0] lo, hi;
    bit       flip;
    bit [7:0] x;
    bit [1:0] pal;
    bit       prio;
    bit       is0;
  } spr_t;

  typedef struct {
    bit [2:0] slot;
    bit [7:0] lo, hi, attr, x;
    bit       s0;
  } ld_t;

  typedef struct {
    logic [3:0] pix;
    logic       beh;
    logic       hit;
    int         sl;
    int         x;
  } exp_t;

  spr_t m [8];
  bit   m_hit;
  exp_t eq [$];
  ld_t  lq [8];
  int   ln;
  int   bg_mode;
  bit [3:0] bg_c;
  bit   spur;
  int   checks;
  int   failures;

  task automatic add_ld(input bit [2:0] s,
                        input bit [7:0] lo, hi, at, x,
                        input bit s0);
    lq[ln] = '{s, lo, hi, at, x, s0};
    ln++;
  endtask

  task automatic cyc(input int sl, x,
                     input bit rst, le,
                     input ld_t l);
    exp_t e;
    int   sx, o, b;
    bit [1:0] c;
    bit   found, s0, set;
    @(negedge clk);
    reset = rst; scanline = 10'(sl);
    x_idx = 10'(x); ld_en = le;
    ld_slot = l.slot; ld_pt_lo = l.lo;
    ld_pt_hi = l.hi; ld_attr = l.attr;
    ld_x = l.x; ld_spr0 = l.s0;
    case (bg_mode)
      0: bg_pixel = 4'h0;
      1: bg_pixel = bg_c;
      default: bg_pixel = 4'($urandom_range(0, 15));
    endcase
    e = '{4'd0, 1'b0, 1'b0, sl, x};
    found = 0; s0 = 0; set = 0;
    sx = x - 1;
    if (!rst && sl >= 1 && sl <= 240 &&
        x >= 1 && x <= 256) begin
      for (int s = 0; s < 8; s++) begin
        if (m[s].v && sx >= int'(m[s].x) &&
            sx < int'(m[s].x) + 8) begin
          o = sx - int'(m[s].x);
          b = m[s].flip ? o : 7 - o;
          c = {m[s].hi[b], m[s].lo[b]};
          if (c != 0) begin
            if (!found) begin
              found = 1;
              e.pix = {m[s].pal, c};
              e.beh = m[s].prio;
            end
            if (m[s].is0) s0 = 1;
          end
        end
      end
      if (!show_spr || (!show_spr_left && sx < 8)) begin
        e.pix = 0; e.beh = 0;
      end
      set = s0 && bg_pixel[1:0] != 0 && show_spr &&
            sx != 255 &&
            !(sx < 8 && (!show_spr_left || !show_bg_left));
    end
    if (rst) m_hit = 0;
    else if (sl == 0 && x == 1) m_hit = 0;
    else if (set) m_hit = 1;
    e.hit = m_hit;
    eq.push_back(e);
    if (rst) begin
      for (int s = 0; s < 8; s++) m[s].v = 0;
    end else begin
      if (x == 257)
        for (int s = 0; s < 8; s++) m[s].v = 0;
      if (le && x >= 257 && x <= 320)
        m[l.slot] = '{1'b1, l.lo, l.hi, l.attr[6],
                      l.x, l.attr[1:0], l.attr[5], l.s0};
    end
  endtask

  task automatic do_line(input int sl, rst_at);
    ld_t l;
    bit  le;
    int  pos;
    for (int x = 0; x <= 340; x++) begin
      le = 0;
      l = '{3'($urandom), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 1'($urandom)};
      for (int k = 0; k < ln; k++) begin
        pos = (k == 0) ? 257 : 257 + k * 9;
        if (x == pos) begin le = 1; l = lq[k]; end
      end
      if (!le && spur && (x < 257 || x > 320) &&
          $urandom_range(0, 15) == 0)
        le = 1;
      cyc(sl, x, x == rst_at, le, l);
    end
    ln = 0;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        checks++;
        if (pixel !== e.pix || spr_behind !== e.beh ||
            spr0_hit !== e.hit) begin
          failures++;
          $display("FAIL out sl=%0d x=%0d got pix=%h beh=%b hit=%b want pix=%h beh=%b hit=%b",
                   e.sl, e.x, pixel, spr_behind,
                   spr0_hit, e.pix, e.beh, e.hit);
        end
      end
    end
  end

  initial begin
    ld_t z;
    int  sl;
    z = '{3'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0};
    ln = 0; bg_mode = 0; bg_c = 0; spur = 0;
    checks = 0; failures = 0; m_hit = 0;
    for (int s = 0; s < 8; s++) m[s] = '{default: 0};
    repeat (3) cyc(0, 0, 1, 0, z);

    add_ld(0, 8'h80, 8'h00, 8'h01, 8'd10, 0);
    do_line(0, -1);
    add_ld(0, 8'h80, 8'h00, 8'h41, 8'd10, 0);
    do_line(1, -1);
    add_ld(2, 8'hFF, 8'h00, 8'h02, 8'd40, 0);
    add_ld(5, 8'hFF, 8'hFF, 8'h23, 8'd40, 0);
    do_line(2, -1);
    add_ld(3, 8'h00, 8'h00, 8'h01, 8'd60, 0);
    add_ld(6, 8'h0F, 8'hF0, 8'h02, 8'd60, 0);
    do_line(3, -1);
    add_ld(1, 8'hFF, 8'h00, 8'h00, 8'd96, 0);
    add_ld(4, 8'hFF, 8'hFF, 8'h03, 8'd100, 1);
    do_line(4, -1);
    bg_mode = 1; bg_c = 4'h1;
    do_line(5, -1);
    do_line(6, -1);
    do_line(240, -1);
    do_line(241, -1);
    add_ld(0, 8'hFF, 8'hFF, 8'h01, 8'd255, 1);
    add_ld(7, 8'hC3, 8'h3C, 8'h02, 8'd252, 0);
    do_line(0, -1);
    add_ld(2, 8'hFF, 8'h00, 8'h01, 8'd2, 1);
    do_line(1, -1);
    show_spr_left = 0; show_bg_left = 0;
    do_line(2, -1);
    show_spr_left = 1; show_bg_left = 1;
    add_ld(0, 8'hFF, 8'hAA, 8'h02, 8'd45, 1);
    do_line(3, -1);
    do_line(4, 50);
    do_line(5, -1);

    spur = 1;
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 7))
        0: sl = 0;
        1: sl = 241 + $urandom_range(0, 20);
        default: sl = $urandom_range(1, 240);
      endcase
      bg_mode = $urandom_range(0, 2);
      bg_c = 4'($urandom_range(0, 15));
      show_spr = $urandom_range(0, 3) != 0;
      show_spr_left = 1'($urandom);
      show_bg_left = 1'($urandom);
      for (int k = $urandom_range(0, 8); k > 0; k--)
        add_ld(3'($urandom), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom_range(0, 255)),
               $urandom_range(0, 3) == 0);
      do_line(sl, -1);
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (eq.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0",
               eq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_spr_shift.md
# ppu_spr_shift

Sprite output stage of the PPU, directly downstream of sprite evaluation and pattern fetch. It holds the eight sprites selected for the next scanline in per-slot pattern shift registers, attribute latches and X down-counters. During visible dots it produces the highest-priority sprite pixel each dot. It also sets the sticky sprite-0 hit flag by comparing sprite 0 against the background pixel.

## Interface

Parameters: none.

- clk  in  1  system clock; one PPU dot per cycle
- reset  in  1  synchronous, active-high reset
- x_idx  in  10  current dot, 0..340
- scanline  in  10  0 = pre-render, 1..240 = visible lines (screen y = scanline-1), others idle
- ld_en  in  1  load strobe for one slot, honoured only for x_idx 257..320
- ld_slot  in  3  slot index 0..7 being loaded
- ld_pt_lo  in  8  pattern plane 0 byte, unflipped (bit 7 = leftmost pixel)
- ld_pt_hi  in  8  pattern plane 1 byte, unflipped
- ld_attr  in  8  OAM byte 2: [1:0] palette, [5] priority (1 = behind background), [6] horizontal flip
- ld_x  in  8  OAM byte 3, sprite left X
- ld_spr0  in  1  slot being loaded holds OAM sprite 0
- bg_pixel  in  4  background pixel for the dot in the same cycle; [1:0]==0 means transparent
- show_spr  in  1  sprite rendering enable
- show_spr_left  in  1  1 = sprites shown in screen x 0..7
- show_bg_left  in  1  1 = background shown in screen x 0..7 (used for hit masking)
- pixel  out  4  {palette, pattern bits}; 0 = transparent
- spr_behind  out  1  priority bit of the winning sprite
- spr0_hit  out  1  sticky sprite-0 hit flag

## Operation

- Slot state (×8): pt_lo[7:0], pt_hi[7:0], pal[1:0], prio, xcnt[7:0], is0.
- Slot clear: when x_idx==257, every slot's pt_lo/pt_hi/is0 are zeroed, making all slots transparent.
- Slot load: when x_idx is 257..320 and ld_en is high, slot ld_slot is written.
  - If ld_attr[6]=1, the pattern bytes are stored bit-reversed. Otherwise they are stored as given.
  - pal, prio and is0 are latched; xcnt ← ld_x.
  - A load in the same cycle as the x_idx==257 clear wins for its slot.
  - ld_en outside 257..320 is ignored.
- Shifting applies on dots x_idx = 1..256 of scanlines 1..240. Screen x = x_idx-1. Per slot:
  - A slot is active when xcnt==0. Its candidate pixel is {pt_hi[7], pt_lo[7]}.
  - If xcnt≠0: xcnt decrements and there is no candidate.
  - If xcnt==0: pt_lo and pt_hi shift left by one, filling with 0.
- Priority: the lowest-numbered active slot with a nonzero candidate wins.
  - Its {pal, candidate} goes to pixel and its prio goes to spr_behind.
  - If there is no winner, pixel=0 and spr_behind=0.
  - Slots are not reloaded between dots 1..256.
- Masking forces pixel=0 and spr_behind=0 when:
  - show_spr=0, or
  - show_spr_left=0 and screen x<8.
- Sprite-0 hit is set when all of the following hold:
  - some slot with is0=1 is active with a nonzero candidate, independent of which slot wins priority;
  - bg_pixel[1:0]≠0;
  - show_spr=1;
  - screen x≠255;
  - not (screen x<8 and (show_spr_left=0 or show_bg_left=0));
  - scanline is 1..240.
- spr0_hit stays set until it is cleared at scanline==0, x_idx==1.
- Outside visible dots, pixel=0 and spr_behind=0.
- Slot state is held outside the shift window and outside visible lines.
- On the pre-render line (scanline 0), dots 1..256 do not shift. Loads at 257..320 still apply.

## Timing

- Reset: pixel=0, spr_behind=0, spr0_hit=0; all slot registers 0.
- Reset takes priority over load, clear and shift in the same cycle.
- Latency is 1 clock: inputs x_idx=d and bg_pixel are sampled at one edge, and pixel/spr_behind for screen x=d-1 are valid after that edge.
- spr0_hit rises on the same edge on which the qualifying pixel is registered.
- A sprite with X=k produces its first pixel at x_idx=k+1 and its last at x_idx=k+8.
- For X≥249, pixels beyond screen x 255 are never shown. Counters stop at dot 256.
- A load at dot 320 followed by dot 1 of the next line is valid. Loaded state is consumed starting at dot 1.

## Test plan

- Slot 0 loaded with X=10, pt_lo=0x80, pt_hi=0x00, attr=0x01 → pixel=4'b0101 exactly at screen x=10 and 0 elsewhere on that line.
- Same pattern with attr=0x41 (flipped) → opaque pixel at screen x=17 only.
- Slots 2 and 5 overlap at X=40 with opaque pixels and different palettes → the slot 2 palette is output.
- Slot 3 is transparent while slot 6 is opaque → the slot 6 pixel is output.
- Sprite 0 in slot 4 at X=100, opaque, with bg_pixel=4'h1 at screen x=100 and a higher-priority opaque slot 1 overlapping → spr0_hit rises after that dot.
  - spr0_hit stays 1 through scanline 240.
  - spr0_hit clears at scanline 0, dot 1.
- Sprite 0 opaque at X=255 with opaque background → no hit.
- Sprite 0 at X=2 with show_bg_left=0 → no hit and pixel=0 at x 0..7 when show_spr_left=0.
- reset asserted mid-line while a slot is active → pixel=0 on the next cycle and all slots transparent until reloaded.
